// File: rtl/dns_pkg.sv
// Shared definitions for the DNS lookup controller: result status codes,
// DNS header flag positions, FSM state encoding and the registered result record.
// Ports: none (package).
package dns_pkg;

  // Result status reported with every completed lookup.
  typedef enum logic [2:0] {
    STATUS_OK       = 3'd0,
    STATUS_NXDOMAIN = 3'd1,
    STATUS_SERVFAIL = 3'd2,
    STATUS_NOANSWER = 3'd3,
    STATUS_TIMEOUT  = 3'd4
  } status_e;

  // DNS header flags word layout.
  localparam int FLAG_QR        = 15;
  localparam int FLAG_RCODE_MSB = 3;
  localparam int FLAG_RCODE_LSB = 0;

  localparam logic [3:0]  RCODE_NOERROR  = 4'd0;
  localparam logic [3:0]  RCODE_NXDOMAIN = 4'd3;
  localparam logic [15:0] DNS_PORT       = 16'd53;

  // Controller states. One lookup is in flight at a time.
  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_DONE
  } state_e;

  // Result record captured on the edge that enters DONE.
  typedef struct packed {
    logic [7:0]  tag;
    logic [2:0]  status;
    logic [31:0] addr;
    logic [1:0]  attempts;
  } result_t;

  // Map a matched reply to a status. Only RCODE and whether any answer
  // records were returned matter here.
  function automatic status_e classify_reply(input logic [3:0] rcode,
                                             input logic       has_answer);
    status_e st;
    if (rcode == RCODE_NOERROR) begin
      st = has_answer ? STATUS_OK : STATUS_NOANSWER;
    end else if (rcode == RCODE_NXDOMAIN) begin
      st = STATUS_NXDOMAIN;
    end else begin
      st = STATUS_SERVFAIL;
    end
    return st;
  endfunction

endpackage

// File: rtl/dns_retry_timer.sv
// Response timeout down-counter for the DNS lookup controller.
// Latency: expire is combinational, high in the last cycle of the timed window.
// Backpressure: none; counts whenever run is high, cleared to 0 when run is low.
// Ports:
//   clk, rst    - clock, synchronous active-high reset
//   load        - load load_value (takes priority over counting)
//   load_value  - timeout length in cycles (must be non-zero)
//   run         - count down while high; counter held at 0 while low
//   expire      - one-cycle pulse: counter reaches 0 on the next edge
module dns_retry_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_value,
  input  logic        run,
  output logic        expire
);

  logic [31:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (!run) begin
      count <= '0;
    end else if (count != 32'd0) begin
      count <= count - 32'd1;
    end
  end

  // Flag the cycle whose edge takes the count from 1 to 0, so the owner
  // can act on that same edge; a load of N gives exactly N running cycles.
  assign expire = run && (count == 32'd1);

endmodule

// File: rtl/dns_query_ctrl.sv
// DNS lookup sequencer: one request in flight, query/timeout/retry, one result per request.
// Latency: request accept -> query command 1 cycle; matched reply -> result valid 1 cycle.
// Backpressure: s_req_ready only in IDLE; query held until m_query_ready; result held until m_result_ready.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   s_req_*             - lookup request (valid/ready) with opaque 8-bit tag
//   m_query_*           - query command to the DNS builder (valid/ready) with ID, tag, addressing
//   s_query_done/error  - builder transmit completion pulse and failure qualifier
//   s_resp_*            - parsed reply header from the RX parser (always accepted)
//   m_result_*          - completed lookup (valid/ready): tag, status, address, retransmissions used
//   busy                - controller not idle
module dns_query_ctrl
  import dns_pkg::*;
#(
  parameter logic [31:0] SERVER_IP      = 32'hC0A80101,
  parameter logic [15:0] SERVER_PORT    = DNS_PORT,
  parameter logic [15:0] LOCAL_PORT     = 16'd5353,
  // Must be non-zero.
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd125000000,
  parameter logic [1:0]  MAX_RETRIES    = 2'd2,
  parameter logic [15:0] TXID_INIT      = 16'h1234
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        s_req_valid,
  output logic        s_req_ready,
  input  logic [7:0]  s_req_tag,

  output logic        m_query_valid,
  input  logic        m_query_ready,
  output logic [15:0] m_query_id,
  output logic [7:0]  m_query_tag,
  output logic [31:0] m_query_dest_ip,
  output logic [15:0] m_query_dest_port,
  output logic [15:0] m_query_src_port,
  input  logic        s_query_done,
  input  logic        s_query_error,

  input  logic        s_resp_valid,
  output logic        s_resp_ready,
  input  logic [31:0] s_resp_src_ip,
  input  logic [15:0] s_resp_dst_port,
  input  logic [15:0] s_resp_id,
  input  logic [15:0] s_resp_flags,
  input  logic [15:0] s_resp_answer_rrs,
  input  logic [31:0] s_resp_addr,

  output logic        m_result_valid,
  input  logic        m_result_ready,
  output logic [7:0]  m_result_tag,
  output logic [2:0]  m_result_status,
  output logic [31:0] m_result_addr,
  output logic [1:0]  m_result_attempts,

  output logic        busy
);

  state_e      state;
  state_e      state_nxt;

  logic [15:0] txid;        // ID the next query attempt will carry
  logic [15:0] last_id;     // ID of the attempt currently outstanding
  logic [7:0]  tag_q;
  logic [1:0]  retry_cnt;
  result_t     res_q;

  logic        req_fire;
  logic        query_fire;
  logic        sent_ok;
  logic        send_failed;
  logic        resp_match;
  logic        timer_expire;
  logic        attempt_failed;
  logic        can_retry;
  status_e     reply_status;

  // Opcode/AA/TC/RD/RA/Z bits carry no meaning for the result.
  logic        unused_flags;
  assign unused_flags = ^s_resp_flags[14:4];

  // The parser is never stalled; replies outside WAIT_RESP are simply ignored.
  assign s_resp_ready = 1'b1;

  assign req_fire    = (state == S_IDLE) && s_req_valid;
  assign query_fire  = (state == S_SEND) && m_query_ready;
  assign sent_ok     = (state == S_WAIT_SENT) && s_query_done && !s_query_error;
  assign send_failed = (state == S_WAIT_SENT) && s_query_done && s_query_error;
  assign can_retry   = (retry_cnt < MAX_RETRIES);

  // Only a reply to the newest attempt counts; IDs of earlier attempts
  // of the same lookup no longer equal last_id and fall out here.
  assign resp_match = (state == S_WAIT_RESP) && s_resp_valid
                   && (s_resp_id == last_id)
                   && s_resp_flags[FLAG_QR]
                   && (s_resp_src_ip == SERVER_IP)
                   && (s_resp_dst_port == LOCAL_PORT);

  // A matching reply on the expiry cycle wins over the timeout.
  assign attempt_failed = send_failed
                       || ((state == S_WAIT_RESP) && timer_expire && !resp_match);

  assign reply_status = classify_reply(s_resp_flags[FLAG_RCODE_MSB:FLAG_RCODE_LSB],
                                       s_resp_answer_rrs != 16'd0);

  dns_retry_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load       (sent_ok),
    .load_value (TIMEOUT_CYCLES),
    .run        (state == S_WAIT_RESP),
    .expire     (timer_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (s_req_valid) state_nxt = S_SEND;
      end
      S_SEND: begin
        if (m_query_ready) state_nxt = S_WAIT_SENT;
      end
      S_WAIT_SENT: begin
        if (s_query_done) begin
          if (!s_query_error) state_nxt = S_WAIT_RESP;
          else if (can_retry)  state_nxt = S_SEND;
          else                 state_nxt = S_DONE;
        end
      end
      S_WAIT_RESP: begin
        if (resp_match)        state_nxt = S_DONE;
        else if (timer_expire) state_nxt = can_retry ? S_SEND : S_DONE;
      end
      S_DONE: begin
        if (m_result_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from the registered state; query fields are zero
  // outside SEND so they only carry meaning alongside m_query_valid.
  always_comb begin
    s_req_ready       = 1'b0;
    m_query_valid     = 1'b0;
    m_query_id        = '0;
    m_query_tag       = '0;
    m_query_dest_ip   = '0;
    m_query_dest_port = '0;
    m_query_src_port  = '0;
    m_result_valid    = 1'b0;
    busy              = 1'b1;
    case (state)
      S_IDLE: begin
        s_req_ready = 1'b1;
        busy        = 1'b0;
      end
      S_SEND: begin
        m_query_valid     = 1'b1;
        m_query_id        = txid;
        m_query_tag       = tag_q;
        m_query_dest_ip   = SERVER_IP;
        m_query_dest_port = SERVER_PORT;
        m_query_src_port  = LOCAL_PORT;
      end
      S_DONE: begin
        m_result_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign m_result_tag      = res_q.tag;
  assign m_result_status   = res_q.status;
  assign m_result_addr     = res_q.addr;
  assign m_result_attempts = res_q.attempts;

  // Request context, transaction ID counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      txid      <= TXID_INIT;
      last_id   <= '0;
      tag_q     <= '0;
      retry_cnt <= '0;
      res_q     <= '0;
    end else begin
      if (req_fire) begin
        tag_q     <= s_req_tag;
        retry_cnt <= '0;
      end

      // Every attempt, including retransmissions, consumes a fresh ID.
      if (query_fire) begin
        last_id <= txid;
        txid    <= txid + 16'd1;
      end

      if (attempt_failed) begin
        if (can_retry) begin
          retry_cnt <= retry_cnt + 2'd1;
        end else begin
          res_q.tag      <= tag_q;
          res_q.status   <= STATUS_TIMEOUT;
          res_q.addr     <= '0;
          res_q.attempts <= retry_cnt;
        end
      end

      if (resp_match) begin
        res_q.tag      <= tag_q;
        res_q.status   <= reply_status;
        res_q.addr     <= (reply_status == STATUS_OK) ? s_resp_addr : 32'd0;
        res_q.attempts <= retry_cnt;
      end
    end
  end

endmodule

// File: tb/tb_dns_query_ctrl.sv
// Self-checking bench for dns_query_ctrl: directed table, randomized lookups
// against a lookup-level reference model, and hand-written timing corners.
module tb_dns_query_ctrl;

  localparam int          TIMEOUT     = 100;
  localparam int          MAX_RETRIES = 2;
  localparam logic [31:0] SERVER_IP   = 32'hC0A80101;
  localparam logic [15:0] SERVER_PORT = 16'd53;
  localparam logic [15:0] LOCAL_PORT  = 16'd5353;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_NXDOMAIN = 3'd1;
  localparam logic [2:0] ST_SERVFAIL = 3'd2;
  localparam logic [2:0] ST_NOANSWER = 3'd3;
  localparam logic [2:0] ST_TIMEOUT  = 3'd4;

  logic        clk;
  logic        rst;
  logic        s_req_valid, s_req_ready;
  logic [7:0]  s_req_tag;
  logic        m_query_valid, m_query_ready;
  logic [15:0] m_query_id;
  logic [7:0]  m_query_tag;
  logic [31:0] m_query_dest_ip;
  logic [15:0] m_query_dest_port, m_query_src_port;
  logic        s_query_done, s_query_error;
  logic        s_resp_valid, s_resp_ready;
  logic [31:0] s_resp_src_ip;
  logic [15:0] s_resp_dst_port, s_resp_id, s_resp_flags, s_resp_answer_rrs;
  logic [31:0] s_resp_addr;
  logic        m_result_valid, m_result_ready;
  logic [7:0]  m_result_tag;
  logic [2:0]  m_result_status;
  logic [31:0] m_result_addr;
  logic [1:0]  m_result_attempts;
  logic        busy;

  dns_query_ctrl #(
    .SERVER_IP      (SERVER_IP),
    .SERVER_PORT    (SERVER_PORT),
    .LOCAL_PORT     (LOCAL_PORT),
    .TIMEOUT_CYCLES (32'd100),
    .MAX_RETRIES    (2'd2),
    .TXID_INIT      (16'h1234)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s_req_valid       (s_req_valid),
    .s_req_ready       (s_req_ready),
    .s_req_tag         (s_req_tag),
    .m_query_valid     (m_query_valid),
    .m_query_ready     (m_query_ready),
    .m_query_id        (m_query_id),
    .m_query_tag       (m_query_tag),
    .m_query_dest_ip   (m_query_dest_ip),
    .m_query_dest_port (m_query_dest_port),
    .m_query_src_port  (m_query_src_port),
    .s_query_done      (s_query_done),
    .s_query_error     (s_query_error),
    .s_resp_valid      (s_resp_valid),
    .s_resp_ready      (s_resp_ready),
    .s_resp_src_ip     (s_resp_src_ip),
    .s_resp_dst_port   (s_resp_dst_port),
    .s_resp_id         (s_resp_id),
    .s_resp_flags      (s_resp_flags),
    .s_resp_answer_rrs (s_resp_answer_rrs),
    .s_resp_addr       (s_resp_addr),
    .m_result_valid    (m_result_valid),
    .m_result_ready    (m_result_ready),
    .m_result_tag      (m_result_tag),
    .m_result_status   (m_result_status),
    .m_result_addr     (m_result_addr),
    .m_result_attempts (m_result_attempts),
    .busy              (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          hs_cnt = 0;       // query handshakes seen on the bus
  logic [15:0] exp_id;           // ID the next query must carry

  always @(posedge clk) if (m_query_valid && m_query_ready) hs_cnt <= hs_cnt + 1;

  // One lookup scenario: the first n_fail attempts fail (timeout or send
  // error), the next one receives a reply with flags/rrs/addr.
  typedef struct {
    logic [7:0]  tag;
    int          n_fail;
    bit          by_err;
    bit          noise;
    logic [15:0] flags;
    logic [15:0] rrs;
    logic [31:0] addr;
    logic [2:0]  exp_status;
    logic [31:0] exp_addr;
    logic [1:0]  exp_att;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] tag, input int nf, input bit err, input bit noise,
                              input logic [15:0] flags, input logic [15:0] rrs, input logic [31:0] addr,
                              input logic [2:0] st, input logic [31:0] ea, input logic [1:0] att);
    vec_t v;
    v.tag = tag; v.n_fail = nf; v.by_err = err; v.noise = noise;
    v.flags = flags; v.rrs = rrs; v.addr = addr;
    v.exp_status = st; v.exp_addr = ea; v.exp_att = att;
    return v;
  endfunction

  // Lookup-level outcome: too many failed attempts -> TIMEOUT after
  // MAX_RETRIES retransmissions, otherwise the reply decides.
  function automatic void ref_model(inout vec_t v);
    int rcode;
    rcode = int'(v.flags) % 16;
    v.exp_addr = 32'd0;
    if (v.n_fail > MAX_RETRIES) begin
      v.exp_status = ST_TIMEOUT;
      v.exp_att    = 2'(MAX_RETRIES);
    end else begin
      v.exp_att = 2'(v.n_fail);
      if (rcode == 0 && v.rrs != 0) begin
        v.exp_status = ST_OK;
        v.exp_addr   = v.addr;
      end else if (rcode == 0) v.exp_status = ST_NOANSWER;
      else if (rcode == 3)     v.exp_status = ST_NXDOMAIN;
      else                     v.exp_status = ST_SERVFAIL;
    end
  endfunction

  task automatic drive_resp(input logic [31:0] ip, input logic [15:0] port, input logic [15:0] id,
                            input logic [15:0] flags, input logic [15:0] rrs, input logic [31:0] addr);
    s_resp_valid = 1'b1; s_resp_src_ip = ip; s_resp_dst_port = port; s_resp_id = id;
    s_resp_flags = flags; s_resp_answer_rrs = rrs; s_resp_addr = addr;
    @(negedge clk);
    s_resp_valid = 1'b0; s_resp_src_ip = '0; s_resp_dst_port = '0; s_resp_id = '0;
    s_resp_flags = '0; s_resp_answer_rrs = '0; s_resp_addr = '0;
  endtask

  task automatic send_req(input logic [7:0] tag);
    int n;
    n = 0;
    while (!s_req_ready && n < 400) begin @(negedge clk); n++; end
    chk("req_ready_wait", s_req_ready, 1'b1);
    s_req_valid = 1'b1; s_req_tag = tag;
    @(negedge clk);
    s_req_valid = 1'b0; s_req_tag = '0;
    chk("req_ready_drop", s_req_ready, 1'b0);
    chk("req_to_query_latency", m_query_valid, 1'b1);
  endtask

  task automatic query_hs(input logic [7:0] tag, output logic [15:0] sent);
    int n;
    n = 0;
    while (!m_query_valid && n < 400) begin @(negedge clk); n++; end
    chk("query_valid_wait", m_query_valid, 1'b1);
    chk("query_id", m_query_id, exp_id);
    chk("query_tag", m_query_tag, tag);
    chk("query_addressing", {m_query_dest_ip, m_query_dest_port, m_query_src_port},
        {SERVER_IP, SERVER_PORT, LOCAL_PORT});
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      chk("query_stable", {m_query_valid, m_query_id, m_query_tag}, {1'b1, exp_id, tag});
    end
    m_query_ready = 1'b1;
    @(negedge clk);
    m_query_ready = 1'b0;
    sent   = exp_id;
    exp_id = exp_id + 16'd1;
    chk("query_valid_drop", m_query_valid, 1'b0);
  endtask

  task automatic send_done(input bit err);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    s_query_done = 1'b1; s_query_error = err;
    @(negedge clk);
    s_query_done = 1'b0; s_query_error = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_query", {m_query_valid, m_query_id, m_query_tag, m_query_dest_ip}, 64'd0);
    chk("rst_query_ports", {m_query_dest_port, m_query_src_port}, 64'd0);
    chk("rst_result", {m_result_valid, m_result_tag, m_result_status, m_result_addr, m_result_attempts}, 64'd0);
    chk("rst_ready_busy", {s_req_ready, s_resp_ready, busy}, 3'b110);
  endtask

  task automatic run_txn(input vec_t v);
    int          base, nq, n;
    logic [15:0] sent;
    bit          err;
    base = hs_cnt;
    nq   = (v.n_fail > MAX_RETRIES) ? MAX_RETRIES + 1 : v.n_fail + 1;
    send_req(v.tag);
    for (int a = 0; a < nq; a++) begin
      query_hs(v.tag, sent);
      if (a < v.n_fail) begin
        err = v.by_err;
        send_done(err);
        // Edges since done was sampled until the next query or the result.
        n = 0;
        while (!(m_query_valid || m_result_valid) && n < 400) begin
          if (n == 5) drive_resp(SERVER_IP, LOCAL_PORT, sent - 16'd1, 16'h8180, 16'd1, 32'hDEAD0001);
          else @(negedge clk);
          n++;
        end
        chk("attempt_fail_gap", n, err ? 0 : TIMEOUT);
      end else begin
        send_done(1'b0);
        repeat ($urandom_range(0, 5)) @(negedge clk);
        // Reply with an older ID must be ignored.
        drive_resp(SERVER_IP, LOCAL_PORT, sent - 16'd1, 16'h8180, 16'd1, 32'hDEAD0002);
        if (v.noise) begin
          drive_resp(32'h08080808, LOCAL_PORT, sent, v.flags, v.rrs, v.addr);
          drive_resp(SERVER_IP, LOCAL_PORT, sent, v.flags & 16'h7FFF, v.rrs, v.addr);
          drive_resp(SERVER_IP, 16'd53, sent, v.flags, v.rrs, v.addr);
        end
        chk("junk_dropped", {m_result_valid, m_query_valid, busy, s_resp_ready}, 4'b0011);
        drive_resp(SERVER_IP, LOCAL_PORT, sent, v.flags, v.rrs, v.addr);
        chk("resp_to_result_latency", m_result_valid, 1'b1);
      end
    end
    n = 0;
    while (!m_result_valid && n < 400) begin @(negedge clk); n++; end
    chk("result_valid", m_result_valid, 1'b1);
    chk("result_tag", m_result_tag, v.tag);
    chk("result_status", m_result_status, v.exp_status);
    chk("result_addr", m_result_addr, v.exp_addr);
    chk("result_attempts", m_result_attempts, v.exp_att);
    chk("query_handshakes", hs_cnt - base, nq);
    m_result_ready = 1'b1;
    @(negedge clk);
    m_result_ready = 1'b0;
    chk("result_release", {m_result_valid, s_req_ready, busy}, 3'b010);
  endtask

  vec_t        tbl[10];
  vec_t        v;
  logic [15:0] id;
  logic [3:0]  rc;

  initial begin
    rst = 1'b1;
    s_req_valid = 0; s_req_tag = '0; m_query_ready = 0; s_query_done = 0; s_query_error = 0;
    s_resp_valid = 0; s_resp_src_ip = '0; s_resp_dst_port = '0; s_resp_id = '0;
    s_resp_flags = '0; s_resp_answer_rrs = '0; s_resp_addr = '0; m_result_ready = 0;
    exp_id = 16'h1234;

    // {tag, n_fail, by_err, noise, flags, rrs, addr} -> {status, addr, attempts}
    tbl[0] = mk(8'h05, 0, 0, 0, 16'h8180, 16'd1, 32'h5DB8D822, ST_OK,       32'h5DB8D822, 2'd0);
    tbl[1] = mk(8'h11, 1, 0, 0, 16'h8180, 16'd2, 32'h0A000001, ST_OK,       32'h0A000001, 2'd1);
    tbl[2] = mk(8'h22, 3, 0, 0, 16'h8180, 16'd1, 32'h11111111, ST_TIMEOUT,  32'd0,        2'd2);
    tbl[3] = mk(8'h33, 0, 0, 1, 16'h8183, 16'd0, 32'h22222222, ST_NXDOMAIN, 32'd0,        2'd0);
    tbl[4] = mk(8'h44, 0, 0, 0, 16'h8180, 16'd0, 32'h33333333, ST_NOANSWER, 32'd0,        2'd0);
    tbl[5] = mk(8'h55, 0, 0, 1, 16'h8182, 16'd1, 32'h44444444, ST_SERVFAIL, 32'd0,        2'd0);
    tbl[6] = mk(8'h66, 1, 1, 0, 16'h8180, 16'd3, 32'hC0A80164, ST_OK,       32'hC0A80164, 2'd1);
    tbl[7] = mk(8'h77, 2, 1, 1, 16'h8185, 16'd1, 32'h55555555, ST_SERVFAIL, 32'd0,        2'd2);
    tbl[8] = mk(8'h88, 3, 1, 0, 16'h8180, 16'd1, 32'h66666666, ST_TIMEOUT,  32'd0,        2'd2);
    tbl[9] = mk(8'h99, 0, 0, 0, 16'h8583, 16'd1, 32'h77777777, ST_NXDOMAIN, 32'd0,        2'd0);

    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_outputs();

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    rc = 4'd0;
        2:       rc = 4'd3;
        default: rc = 4'($urandom_range(1, 15));
      endcase
      v = mk(8'($urandom), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
             {1'b1, 11'($urandom), rc}, 16'($urandom_range(0, 2)), $urandom,
             3'd0, 32'd0, 2'd0);
      ref_model(v);
      run_txn(v);
    end

    // Matching reply on the very cycle the timer expires: no retry.
    send_req(8'hA0);
    query_hs(8'hA0, id);
    send_done(1'b0);
    repeat (TIMEOUT - 1) @(negedge clk);
    chk("pre_expiry_waiting", {m_query_valid, m_result_valid, busy}, 3'b001);
    drive_resp(SERVER_IP, LOCAL_PORT, id, 16'h8180, 16'd1, 32'h01020304);
    chk("collision_no_retry", {m_result_valid, m_query_valid}, 2'b10);
    chk("collision_result", {m_result_status, m_result_addr, m_result_attempts},
        {ST_OK, 32'h01020304, 2'd0});

    // Result held under backpressure while a new request is pending.
    s_req_valid = 1'b1; s_req_tag = 8'hBB;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("result_backpressure",
          {m_result_valid, s_req_ready, m_result_tag, m_result_status, m_result_addr, m_result_attempts},
          {1'b1, 1'b0, 8'hA0, ST_OK, 32'h01020304, 2'd0});
    end
    m_result_ready = 1'b1;
    @(negedge clk);
    m_result_ready = 1'b0;
    chk("idle_after_result", {m_result_valid, s_req_ready}, 2'b01);
    @(negedge clk);
    s_req_valid = 1'b0; s_req_tag = '0;
    chk("back_to_back_accept", m_query_valid, 1'b1);
    query_hs(8'hBB, id);
    send_done(1'b0);
    repeat (10) @(negedge clk);
    chk("waiting_before_reset", {busy, m_query_valid, m_result_valid}, 3'b100);

    // Reset in the middle of waiting for a reply.
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    exp_id = 16'h1234;
    run_txn(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dns_query_ctrl.md
Name: dns_query_ctrl

Overview:
- Sequences DNS lookups for the UDP/IP stack, with one transaction in flight at a time.
- Accepts tagged lookup requests and assigns a 16-bit transaction ID for each attempt.
- Commands the DNS query builder (UDP TX side), then waits for the parsed response from the DNS RX parser.
- Matches the response to the outstanding ID, handles timeout and retry, and returns one status/address result per request.

Parameters:
- SERVER_IP, 32'hC0A80101, DNS server IPv4 address; used as query dest and to filter responses.
- SERVER_PORT, 16'd53, DNS server UDP port.
- LOCAL_PORT, 16'd5353, UDP source port for queries; responses must target it.
- TIMEOUT_CYCLES, 32'd125000000, cycles to wait for a response after the query is sent.
- MAX_RETRIES, 2, retransmissions after the first attempt; width 2 bits, range 0..3.
- TXID_INIT, 16'h1234, transaction ID counter value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_req_valid  in  1  lookup request valid
- s_req_ready  out  1  controller can accept a request
- s_req_tag  in  8  opaque requester tag, echoed in query and result
- m_query_valid  out  1  query command valid to builder
- m_query_ready  in  1  builder accepts command
- m_query_id  out  16  transaction ID for this attempt
- m_query_tag  out  8  request tag (builder selects QNAME)
- m_query_dest_ip  out  32  SERVER_IP
- m_query_dest_port  out  16  SERVER_PORT
- m_query_src_port  out  16  LOCAL_PORT
- s_query_done  in  1  one-cycle pulse: builder finished transmitting
- s_query_error  in  1  qualified by s_query_done: transmit failed
- s_resp_valid  in  1  parsed response header valid from RX parser
- s_resp_ready  out  1  response accepted
- s_resp_src_ip  in  32  response source IP
- s_resp_dst_port  in  16  response UDP destination port
- s_resp_id  in  16  DNS transaction ID
- s_resp_flags  in  16  DNS flags word
- s_resp_answer_rrs  in  16  answer record count
- s_resp_addr  in  32  first A-record address
- m_result_valid  out  1  result valid
- m_result_ready  in  1  result consumed
- m_result_tag  out  8  tag of the completed request
- m_result_status  out  3  status code (see package)
- m_result_addr  out  32  resolved address; 0 unless status is OK
- m_result_attempts  out  2  number of retransmissions used
- busy  out  1  high whenever the state is not IDLE

Behaviour:
- Reset state: IDLE. Every output is 0, except s_req_ready=1 and s_resp_ready=1. Transaction ID counter = TXID_INIT; retry count = 0.
- s_resp_ready is held at 1 in all states. A response accepted outside WAIT_RESP is discarded.
- IDLE:
  - s_req_ready=1.
  - On s_req_valid: latch the tag, clear the retry count, go to SEND. s_req_ready drops the following cycle.
- SEND:
  - m_query_valid=1; m_query_id = current counter value.
  - On m_query_ready: go to WAIT_SENT. The counter increments on the same edge, wrapping FFFF->0000.
  - m_query_* fields are stable while m_query_valid is high.
- WAIT_SENT:
  - On s_query_done with s_query_error=0: load the timer with TIMEOUT_CYCLES, go to WAIT_RESP.
  - On s_query_done with s_query_error=1: treat exactly as a timeout (retry or fail).
- WAIT_RESP:
  - The timer decrements once per cycle.
  - A response matches when all of these hold: s_resp_id equals the ID last sent, flags[15] (QR)=1, s_resp_src_ip=SERVER_IP, s_resp_dst_port=LOCAL_PORT.
  - Non-matching responses are dropped; the state machine stays in WAIT_RESP.
  - Match with RCODE (flags[3:0])=0 and answer_rrs!=0: status OK, addr=s_resp_addr.
  - Match with RCODE=0 and answer_rrs=0: status NOANSWER.
  - Match with RCODE=3: status NXDOMAIN.
  - Match with any other RCODE: status SERVFAIL.
  - Any match goes to DONE.
  - Timer reaches 0 with retry count < MAX_RETRIES: increment the retry count, go to SEND with the new ID.
  - Timer reaches 0 with retry count = MAX_RETRIES: status TIMEOUT, go to DONE.
  - A matching response in the same cycle the timer expires wins; no retry is issued.
  - A reply carrying an ID from an earlier attempt is a mismatch and is dropped.
- DONE:
  - m_result_valid=1 with all result fields registered and stable.
  - On m_result_ready: go to IDLE. A request can be accepted in the cycle after the result handshake.
- Latency: request accept to query command = 1 cycle; matched response to m_result_valid = 1 cycle.
- Reset mid-operation: state returns to IDLE and the counter reloads TXID_INIT. The builder must tolerate m_query_valid dropping.
- Timer: 32-bit down-counter. TIMEOUT_CYCLES=0 is illegal.

Decomposition:
- Shared package dns_pkg:
  - Status codes: OK=0, NXDOMAIN=1, SERVFAIL=2, NOANSWER=3, TIMEOUT=4.
  - Flag bit positions: QR=15, RCODE=[3:0].
  - Constants: RCODE_NXDOMAIN=3, DNS_PORT=53.
- One sub-module, dns_retry_timer:
  - Inputs: load, load value.
  - Output: expire pulse.
  - Holds 0 when idle.
- The FSM, ID counter and match logic stay in dns_query_ctrl.

Test Plan:
- Nominal lookup (TIMEOUT_CYCLES=100): tag 8'h05; builder returns done; response id=16'h1234, flags=16'h8180, answer_rrs=1, addr=32'h5DB8D822 -> result status OK, addr 5DB8D822, attempts 0; next request uses id 1235.
- Single timeout then success (MAX_RETRIES=2): first attempt gets no response; at cycle 100 after done, a second query is issued with id 1235; response with id 1235 arrives -> status OK, attempts 1. A late response with id 1234 is dropped.
- Exhausted retries: no responses to ids 1234, 1235, 1236 -> status TIMEOUT, attempts 2, addr 0; exactly 3 query handshakes observed.
- Filtering: while waiting on id 1234, send src_ip 32'h08080808, then QR=0, then dst_port 53 -> all dropped, still waiting. Then flags=16'h8183 from SERVER_IP -> status NXDOMAIN.
- Collision and backpressure: a matching response arrives on the exact cycle the timer expires -> result OK with no retry. m_result_ready held low 10 cycles -> result stable and s_req_ready stays 0 throughout.
- Reset mid-WAIT_RESP: assert rst for 1 cycle -> all outputs reset, next query id 1234. s_query_error=1 on done -> immediate retry with the next id.
